// File: rtl/axi_fw_pkg.sv
// Shared definitions for the per-master AXI firewall: region map, response codes,
// FSM state types and the start-address region check.
package axi_fw_pkg;

    localparam int          NUM_REGIONS = 7;
    localparam logic [63:0] REGION_SIZE = 64'h1000;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_DECERR = 2'b11;

    // Slave k owns the 4 KiB page starting at REGION_BASE[k]
    localparam logic [63:0] REGION_BASE [NUM_REGIONS] = '{
        64'h1000, 64'h2000, 64'h3000, 64'h4000, 64'h5000, 64'h6000, 64'h7000
    };

    typedef enum logic [1:0] {W_PASS, W_DRAIN, W_RESP} wr_state_t;
    typedef enum logic       {R_PASS, R_ERR}           rd_state_t;

    function automatic logic fw_region_allowed(input logic [63:0] addr,
                                               input logic [NUM_REGIONS-1:0] mask);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < NUM_REGIONS; k++) begin
            if (mask[k] && addr >= REGION_BASE[k] && (addr - REGION_BASE[k]) < REGION_SIZE)
                ok = 1'b1;
        end
        return ok;
    endfunction

endpackage

// File: rtl/axi_fw_err_rd_gen.sv
// Read-side error engine: after a denied AR it produces arlen+1 DECERR beats
// upstream, then hands the R channel back to the pass-through path.
// state  | meaning
// R_PASS | R channel owned by the fabric
// R_ERR  | locally generating DECERR beats for the latched id
module axi_fw_err_rd_gen
    import axi_fw_pkg::*;
#(
    parameter int ID_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic [ID_W-1:0] i_id,
    input  logic [7:0]      i_len,
    input  logic            i_rready,
    output logic            o_busy,
    output logic [ID_W-1:0] o_rid,
    output logic            o_rlast
);

    rd_state_t       r_state;
    logic [7:0]      r_beat;
    logic [7:0]      r_len;
    logic [ID_W-1:0] r_id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= R_PASS;
            r_beat  <= '0;
            r_len   <= '0;
            r_id    <= '0;
        end else begin
            case (r_state)
                R_PASS: if (i_start) begin
                    r_state <= R_ERR;
                    r_id    <= i_id;
                    r_len   <= i_len;
                    r_beat  <= '0;
                end
                R_ERR: if (i_rready) begin
                    if (r_beat == r_len) r_state <= R_PASS;
                    else                 r_beat  <= r_beat + 8'd1;
                end
                default: r_state <= R_PASS;
            endcase
        end
    end

    assign o_busy  = (r_state == R_ERR);
    assign o_rid   = r_id;
    assign o_rlast = o_busy && (r_beat == r_len);

endmodule

// File: rtl/axi_master_firewall.sv
// Per-master AXI firewall: allowed requests pass through unchanged, denied ones are
// absorbed and completed with DECERR. Define FW_VIOLATION_LOG_EN for violation logging ports.
// state   | meaning
// W_PASS  | AW/W/B pass through; denied AW waits for wr_out==0
// W_DRAIN | swallowing W beats of a denied write
// W_RESP  | returning DECERR B for the denied write
module axi_master_firewall
    import axi_fw_pkg::*;
#(
    parameter int                    ADDR_W     = 32,
    parameter int                    DATA_W     = 32,
    parameter int                    ID_W       = 4,
    parameter int                    NUM_SLAVES = 7,
    parameter logic [NUM_SLAVES-1:0] ALLOW_MASK = 7'b0010110,
    parameter int                    MAX_OUT    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ID_W-1:0]     s_awid,
    input  logic [ADDR_W-1:0]   s_awaddr,
    input  logic [7:0]          s_awlen,
    input  logic [2:0]          s_awsize,
    input  logic [1:0]          s_awburst,
    input  logic                s_awlock,
    input  logic [3:0]          s_awcache,
    input  logic [2:0]          s_awprot,
    input  logic [3:0]          s_awqos,
    input  logic [3:0]          s_awregion,
    input  logic                s_awvalid,
    output logic                s_awready,
    input  logic [DATA_W-1:0]   s_wdata,
    input  logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_wlast,
    input  logic                s_wvalid,
    output logic                s_wready,
    output logic [ID_W-1:0]     s_bid,
    output logic [1:0]          s_bresp,
    output logic                s_bvalid,
    input  logic                s_bready,
    input  logic [ID_W-1:0]     s_arid,
    input  logic [ADDR_W-1:0]   s_araddr,
    input  logic [7:0]          s_arlen,
    input  logic [2:0]          s_arsize,
    input  logic [1:0]          s_arburst,
    input  logic                s_arlock,
    input  logic [3:0]          s_arcache,
    input  logic [2:0]          s_arprot,
    input  logic [3:0]          s_arqos,
    input  logic [3:0]          s_arregion,
    input  logic                s_arvalid,
    output logic                s_arready,
    output logic [ID_W-1:0]     s_rid,
    output logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          s_rresp,
    output logic                s_rlast,
    output logic                s_rvalid,
    input  logic                s_rready,
    output logic [ID_W-1:0]     m_awid,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [7:0]          m_awlen,
    output logic [2:0]          m_awsize,
    output logic [1:0]          m_awburst,
    output logic                m_awlock,
    output logic [3:0]          m_awcache,
    output logic [2:0]          m_awprot,
    output logic [3:0]          m_awqos,
    output logic [3:0]          m_awregion,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wlast,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [ID_W-1:0]     m_bid,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready,
    output logic [ID_W-1:0]     m_arid,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic [7:0]          m_arlen,
    output logic [2:0]          m_arsize,
    output logic [1:0]          m_arburst,
    output logic                m_arlock,
    output logic [3:0]          m_arcache,
    output logic [2:0]          m_arprot,
    output logic [3:0]          m_arqos,
    output logic [3:0]          m_arregion,
    output logic                m_arvalid,
    input  logic                m_arready,
    input  logic [ID_W-1:0]     m_rid,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rlast,
    input  logic                m_rvalid,
    output logic                m_rready,
`ifdef FW_VIOLATION_LOG_EN
    output logic [15:0]         fw_viol_cnt,
    output logic [ADDR_W-1:0]   fw_first_addr,
    output logic [0:0]          fw_first_is_wr,
`endif
    output logic                fw_violation
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);

    wr_state_t       r_wstate;
    logic [ID_W-1:0] r_bid;
    logic [CNT_W-1:0] r_wr_out, r_rd_out;
    logic            r_fw_violation;
    logic            w_aw_allow, w_ar_allow, w_wr_full, w_rd_full;
    logic            w_aw_deny_hs, w_ar_deny_hs, w_rd_busy, w_err_rlast;
    logic            w_m_aw_hs, w_m_b_hs, w_m_ar_hs, w_m_r_done;
    logic [ID_W-1:0] w_err_rid;

    assign {m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awlock, m_awcache,
            m_awprot, m_awqos, m_awregion} = {s_awid, s_awaddr, s_awlen, s_awsize,
            s_awburst, s_awlock, s_awcache, s_awprot, s_awqos, s_awregion};
    assign {m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock, m_arcache,
            m_arprot, m_arqos, m_arregion} = {s_arid, s_araddr, s_arlen, s_arsize,
            s_arburst, s_arlock, s_arcache, s_arprot, s_arqos, s_arregion};
    assign {m_wdata, m_wstrb, m_wlast} = {s_wdata, s_wstrb, s_wlast};

    assign w_aw_allow = fw_region_allowed(64'(s_awaddr), ALLOW_MASK);
    assign w_ar_allow = fw_region_allowed(64'(s_araddr), ALLOW_MASK);
    assign w_wr_full  = (r_wr_out == CNT_W'(MAX_OUT));
    assign w_rd_full  = (r_rd_out == CNT_W'(MAX_OUT));

    always_comb begin
        m_awvalid = 1'b0;
        s_awready = 1'b0;
        m_wvalid  = 1'b0;
        s_wready  = 1'b0;
        s_bvalid  = 1'b0;
        s_bid     = m_bid;
        s_bresp   = m_bresp;
        m_bready  = 1'b0;
        case (r_wstate)
            W_PASS: begin
                if (w_aw_allow) begin
                    m_awvalid = s_awvalid && !w_wr_full;
                    s_awready = m_awready && !w_wr_full;
                end else begin
                    s_awready = (r_wr_out == '0);
                end
                m_wvalid = s_wvalid;
                s_wready = m_wready;
                s_bvalid = m_bvalid;
                m_bready = s_bready;
            end
            W_DRAIN: s_wready = 1'b1;
            W_RESP: begin
                s_bvalid = 1'b1;
                s_bid    = r_bid;
                s_bresp  = RESP_DECERR;
            end
            default: ;
        endcase
    end

    assign w_aw_deny_hs = (r_wstate == W_PASS) && s_awvalid && !w_aw_allow && (r_wr_out == '0);
    assign w_m_aw_hs    = m_awvalid && m_awready;
    assign w_m_b_hs     = m_bvalid && m_bready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wstate <= W_PASS;
            r_bid    <= '0;
        end else begin
            case (r_wstate)
                W_PASS: if (w_aw_deny_hs) begin
                    r_wstate <= W_DRAIN;
                    r_bid    <= s_awid;
                end
                W_DRAIN: if (s_wvalid && s_wlast) r_wstate <= W_RESP;
                W_RESP:  if (s_bready)            r_wstate <= W_PASS;
                default: r_wstate <= W_PASS;
            endcase
        end
    end

    // Read path: the error engine owns the R channel while busy
    assign m_arvalid    = !w_rd_busy && w_ar_allow && s_arvalid && !w_rd_full;
    assign s_arready    = !w_rd_busy && (w_ar_allow ? (m_arready && !w_rd_full) : (r_rd_out == '0));
    assign w_ar_deny_hs = !w_rd_busy && s_arvalid && !w_ar_allow && (r_rd_out == '0);
    assign m_rready     = !w_rd_busy && s_rready;
    assign s_rvalid     = w_rd_busy ? 1'b1        : m_rvalid;
    assign s_rid        = w_rd_busy ? w_err_rid   : m_rid;
    assign s_rdata      = w_rd_busy ? '0          : m_rdata;
    assign s_rresp      = w_rd_busy ? RESP_DECERR : m_rresp;
    assign s_rlast      = w_rd_busy ? w_err_rlast : m_rlast;
    assign w_m_ar_hs    = m_arvalid && m_arready;
    assign w_m_r_done   = m_rvalid && m_rready && m_rlast;

    axi_fw_err_rd_gen #(.ID_W(ID_W)) u_err_rd (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_ar_deny_hs),
        .i_id     (s_arid),
        .i_len    (s_arlen),
        .i_rready (s_rready),
        .o_busy   (w_rd_busy),
        .o_rid    (w_err_rid),
        .o_rlast  (w_err_rlast)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_out       <= '0;
            r_rd_out       <= '0;
            r_fw_violation <= 1'b0;
        end else begin
            if (w_m_aw_hs && !w_m_b_hs)      r_wr_out <= r_wr_out + 1'b1;
            else if (!w_m_aw_hs && w_m_b_hs) r_wr_out <= r_wr_out - 1'b1;
            if (w_m_ar_hs && !w_m_r_done)      r_rd_out <= r_rd_out + 1'b1;
            else if (!w_m_ar_hs && w_m_r_done) r_rd_out <= r_rd_out - 1'b1;
            r_fw_violation <= w_aw_deny_hs || w_ar_deny_hs;
        end
    end

    assign fw_violation = r_fw_violation;

`ifdef FW_VIOLATION_LOG_EN
    logic [15:0]       r_viol_cnt;
    logic [ADDR_W-1:0] r_first_addr;
    logic              r_first_is_wr;
    logic              r_logged;
    logic [15:0]       w_n_deny;

    assign w_n_deny = 16'(w_aw_deny_hs) + 16'(w_ar_deny_hs);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_viol_cnt    <= '0;
            r_first_addr  <= '0;
            r_first_is_wr <= 1'b0;
            r_logged      <= 1'b0;
        end else if (w_aw_deny_hs || w_ar_deny_hs) begin
            r_viol_cnt <= (r_viol_cnt > 16'hFFFF - w_n_deny) ? 16'hFFFF : r_viol_cnt + w_n_deny;
            if (!r_logged) begin
                r_logged      <= 1'b1;
                r_first_addr  <= w_aw_deny_hs ? s_awaddr : s_araddr;
                r_first_is_wr <= w_aw_deny_hs;
            end
        end
    end

    assign fw_viol_cnt    = r_viol_cnt;
    assign fw_first_addr  = r_first_addr;
    assign fw_first_is_wr = r_first_is_wr;
`endif

endmodule

// File: tb/tb_axi_master_firewall.sv
// Directed bench for axi_master_firewall (M2 mask: S1,S2,S4 = pages 0x2000,0x3000,0x5000)
// with a transaction-level reference model checked every cycle.
module tb_axi_master_firewall;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  s_awid, s_arid, s_bid, s_rid, m_awid, m_arid, m_bid, m_rid;
    logic [31:0] s_awaddr, s_araddr, m_awaddr, m_araddr;
    logic [7:0]  s_awlen, s_arlen, m_awlen, m_arlen;
    logic [2:0]  s_awsize, s_arsize, m_awsize, m_arsize, s_awprot, s_arprot, m_awprot, m_arprot;
    logic [1:0]  s_awburst, s_arburst, m_awburst, m_arburst;
    logic        s_awlock, s_arlock, m_awlock, m_arlock;
    logic [3:0]  s_awcache, s_arcache, m_awcache, m_arcache, s_awqos, s_arqos, m_awqos, m_arqos;
    logic [3:0]  s_awregion, s_arregion, m_awregion, m_arregion;
    logic        s_awvalid, s_awready, s_arvalid, s_arready, m_awvalid, m_awready, m_arvalid, m_arready;
    logic [31:0] s_wdata, m_wdata, s_rdata, m_rdata;
    logic [3:0]  s_wstrb, m_wstrb;
    logic        s_wlast, s_wvalid, s_wready, m_wlast, m_wvalid, m_wready;
    logic [1:0]  s_bresp, m_bresp, s_rresp, m_rresp;
    logic        s_bvalid, s_bready, m_bvalid, m_bready;
    logic        s_rlast, s_rvalid, s_rready, m_rlast, m_rvalid, m_rready;
    logic        fw_violation;

    axi_master_firewall dut (
        .clk(clk), .rst(rst),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awburst(s_awburst), .s_awlock(s_awlock), .s_awcache(s_awcache), .s_awprot(s_awprot),
        .s_awqos(s_awqos), .s_awregion(s_awregion), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arcache(s_arcache), .s_arprot(s_arprot),
        .s_arqos(s_arqos), .s_arregion(s_arregion), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid),
        .s_rready(s_rready),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot),
        .m_awqos(m_awqos), .m_awregion(m_awregion), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
        .m_arqos(m_arqos), .m_arregion(m_arregion), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
        .m_rready(m_rready),
        .fw_violation(fw_violation)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Allowed pages for this master: S1 (0x2000), S2 (0x3000), S4 (0x5000)
    function automatic logic allowed(input logic [31:0] a);
        int page;
        page = int'(a / 32'h1000);
        return (page == 2) || (page == 3) || (page == 5);
    endfunction

    // ---------------- reference model ----------------
    int         mw_out, mr_out;
    int         wmode;               // 0 pass, 1 swallowing data, 2 owing error B
    logic [3:0] mdl_bid, mdl_rid;
    logic       rerr;
    int         rbeat, rlen;
    logic       mdl_viol;

    logic exp_m_awvalid, exp_s_awready, exp_m_wvalid, exp_s_wready, exp_s_bvalid, exp_m_bready;
    logic exp_m_arvalid, exp_s_arready, exp_s_rvalid, exp_s_rlast, exp_m_rready;
    logic aw_deny_ok, ar_deny_ok;

    always_comb begin
        exp_m_awvalid = 1'b0;
        exp_s_awready = 1'b0;
        exp_m_wvalid  = 1'b0;
        exp_s_wready  = 1'b0;
        exp_s_bvalid  = 1'b0;
        exp_m_bready  = 1'b0;
        aw_deny_ok    = 1'b0;
        if (wmode == 0) begin
            exp_m_awvalid = s_awvalid && allowed(s_awaddr) && (mw_out < 8);
            exp_s_awready = allowed(s_awaddr) ? (m_awready && mw_out < 8) : (mw_out == 0);
            aw_deny_ok    = s_awvalid && !allowed(s_awaddr) && (mw_out == 0);
            exp_m_wvalid  = s_wvalid;
            exp_s_wready  = m_wready;
            exp_s_bvalid  = m_bvalid;
            exp_m_bready  = s_bready;
        end else if (wmode == 1) begin
            exp_s_wready  = 1'b1;
        end else begin
            exp_s_bvalid  = 1'b1;
        end
        exp_m_arvalid = !rerr && s_arvalid && allowed(s_araddr) && (mr_out < 8);
        exp_s_arready = !rerr && (allowed(s_araddr) ? (m_arready && mr_out < 8) : (mr_out == 0));
        ar_deny_ok    = !rerr && s_arvalid && !allowed(s_araddr) && (mr_out == 0);
        exp_s_rvalid  = rerr ? 1'b1 : m_rvalid;
        exp_s_rlast   = rerr ? (rbeat == rlen) : m_rlast;
        exp_m_rready  = !rerr && s_rready;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mw_out <= 0; mr_out <= 0; wmode <= 0; rerr <= 1'b0;
            rbeat <= 0; rlen <= 0; mdl_bid <= '0; mdl_rid <= '0; mdl_viol <= 1'b0;
        end else begin
            mw_out <= mw_out + int'(exp_m_awvalid && m_awready) - int'(m_bvalid && exp_m_bready);
            mr_out <= mr_out + int'(exp_m_arvalid && m_arready) - int'(m_rvalid && m_rlast && exp_m_rready);
            mdl_viol <= aw_deny_ok || ar_deny_ok;
            if (aw_deny_ok) begin
                wmode <= 1; mdl_bid <= s_awid;
            end else if (wmode == 1 && s_wvalid && s_wlast) wmode <= 2;
            else if (wmode == 2 && s_bready) wmode <= 0;
            if (ar_deny_ok) begin
                rerr <= 1'b1; mdl_rid <= s_arid; rlen <= int'(s_arlen); rbeat <= 0;
            end else if (rerr && s_rready) begin
                if (rbeat == rlen) rerr <= 1'b0;
                else rbeat <= rbeat + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("m_awvalid", m_awvalid, exp_m_awvalid);
            chk("s_awready", s_awready, exp_s_awready);
            chk("m_awaddr", m_awaddr, s_awaddr);
            chk("m_wvalid", m_wvalid, exp_m_wvalid);
            chk("s_wready", s_wready, exp_s_wready);
            chk("s_bvalid", s_bvalid, exp_s_bvalid);
            chk("m_bready", m_bready, exp_m_bready);
            if (wmode == 2) begin
                chk("s_bid err", s_bid, mdl_bid);
                chk("s_bresp err", s_bresp, 2'b11);
            end
            chk("m_arvalid", m_arvalid, exp_m_arvalid);
            chk("s_arready", s_arready, exp_s_arready);
            chk("s_rvalid", s_rvalid, exp_s_rvalid);
            chk("s_rlast", s_rlast, exp_s_rlast);
            chk("m_rready", m_rready, exp_m_rready);
            chk("s_rdata", s_rdata, rerr ? 32'h0 : m_rdata);
            if (rerr) begin
                chk("s_rid err", s_rid, mdl_rid);
                chk("s_rresp err", s_rresp, 2'b11);
            end
            chk("fw_violation", fw_violation, mdl_viol);
        end
    end

    // event counters for the directed literal checks
    int n_maw = 0, n_mw = 0, n_viol = 0, n_sr = 0, n_rlast_idx = 0;
    always @(posedge clk) begin
        if (!rst) begin
            if (m_awvalid) n_maw <= n_maw + 1;
            if (m_wvalid && m_wready) n_mw <= n_mw + 1;
            if (fw_violation) n_viol <= n_viol + 1;
            if (s_rvalid && s_rready) begin
                n_sr <= n_sr + 1;
                if (s_rlast) n_rlast_idx <= n_sr + 1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int v0, a0, w0, r0;
    logic rpat [5];

    initial begin
        s_awid = 0; s_awaddr = 0; s_awlen = 0; s_awsize = 3'd2; s_awburst = 2'd1; s_awlock = 0;
        s_awcache = 0; s_awprot = 0; s_awqos = 0; s_awregion = 0; s_awvalid = 0;
        s_arid = 0; s_araddr = 0; s_arlen = 0; s_arsize = 3'd2; s_arburst = 2'd1; s_arlock = 0;
        s_arcache = 0; s_arprot = 0; s_arqos = 0; s_arregion = 0; s_arvalid = 0;
        s_wdata = 0; s_wstrb = 4'hF; s_wlast = 0; s_wvalid = 0; s_bready = 1; s_rready = 1;
        m_awready = 1; m_wready = 1; m_arready = 1;
        m_bid = 0; m_bresp = 0; m_bvalid = 0;
        m_rid = 0; m_rdata = 0; m_rresp = 0; m_rlast = 0; m_rvalid = 0;
        repeat (3) tick;
        rst = 0;
        #1;
        chk("reset s_bvalid", s_bvalid, 0);
        chk("reset s_rvalid", s_rvalid, 0);
        chk("reset fw_violation", fw_violation, 0);
        chk("reset m_wvalid", m_wvalid, 0);

        // allowed write of four beats
        v0 = n_viol;
        tick;
        s_awvalid = 1; s_awaddr = 32'h2010; s_awlen = 3; s_awid = 1;
        #1 chk("t1 m_awvalid", m_awvalid, 1);
        tick;
        s_awvalid = 0;
        w0 = n_mw;
        s_wvalid = 1;
        for (int i = 0; i < 4; i++) begin
            s_wdata = 32'h100 + i; s_wlast = (i == 3);
            tick;
        end
        s_wvalid = 0; s_wlast = 0;
        chk("t1 beats passed", n_mw - w0, 4);
        m_bvalid = 1; m_bid = 1; m_bresp = 2'b00;
        #1 chk("t1 s_bvalid", s_bvalid, 1);
        chk("t1 s_bresp", s_bresp, 2'b00);
        tick;
        m_bvalid = 0;
        tick;
        chk("t1 no violation", n_viol - v0, 0);

        // denied write to S5
        v0 = n_viol; a0 = n_maw; w0 = n_mw;
        s_awvalid = 1; s_awaddr = 32'h6000; s_awid = 5; s_awlen = 1;
        #1 chk("t2 s_awready", s_awready, 1);
        tick;
        s_awvalid = 0;
        s_wvalid = 1; s_wlast = 0;
        tick;
        s_wlast = 1;
        #1 chk("t2 b early", s_bvalid, 0);
        tick;
        chk("t2 s_bvalid", s_bvalid, 1);
        chk("t2 s_bid", s_bid, 5);
        chk("t2 s_bresp", s_bresp, 2'b11);
        s_wvalid = 0; s_wlast = 0;
        tick;
        chk("t2 b done", s_bvalid, 0);
        chk("t2 m_awvalid never", n_maw - a0, 0);
        chk("t2 m_wvalid never", n_mw - w0, 0);
        chk("t2 one violation", n_viol - v0, 1);

        // denied read to S0 with rready pattern 1,0,1,1,1
        r0 = n_sr;
        rpat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        s_arvalid = 1; s_araddr = 32'h1000; s_arid = 3; s_arlen = 3;
        #1 chk("t3 s_arready", s_arready, 1);
        tick;
        s_arvalid = 0;
        for (int i = 0; i < 5; i++) begin
            s_rready = rpat[i];
            #1 chk("t3 s_rvalid held", s_rvalid, 1);
            tick;
        end
        s_rready = 1;
        chk("t3 beat count", n_sr - r0, 4);
        chk("t3 rlast on fourth", n_rlast_idx - r0, 4);
        chk("t3 rvalid drops", s_rvalid, 0);

        // outstanding limit: ninth AW stalls until a B returns
        s_awvalid = 1; s_awaddr = 32'h3000; s_awid = 2; s_awlen = 0;
        repeat (8) tick;
        #1 chk("t4 ninth stalled ready", s_awready, 0);
        chk("t4 ninth stalled valid", m_awvalid, 0);
        m_bvalid = 1; m_bid = 2; m_bresp = 0;
        #1 chk("t4 still stalled", s_awready, 0);
        tick;
        m_bvalid = 0;
        #1 chk("t4 ninth accepted", s_awready, 1);
        tick;
        s_awvalid = 0;
        m_bvalid = 1;
        repeat (8) tick;
        m_bvalid = 0;

        // denied AW while two writes are outstanding
        s_awvalid = 1; s_awaddr = 32'h5000; s_awid = 6;
        repeat (2) tick;
        s_awaddr = 32'h4000; s_awid = 7;
        #1 chk("t5 held wr_out=2", s_awready, 0);
        m_bvalid = 1; m_bid = 6;
        tick;
        #1 chk("t5 held wr_out=1", s_awready, 0);
        tick;
        m_bvalid = 0;
        #1 chk("t5 accepted", s_awready, 1);
        tick;
        s_awvalid = 0;
        s_wvalid = 1; s_wlast = 1;
        tick;
        s_wvalid = 0; s_wlast = 0;
        chk("t5 s_bid", s_bid, 7);
        tick;

        // reset in the middle of an error read burst
        s_arvalid = 1; s_araddr = 32'h7000; s_arid = 2; s_arlen = 3;
        tick;
        s_arvalid = 0;
        repeat (2) tick;
        rst = 1;
        #1 chk("t6 rvalid on reset", s_rvalid, 0);
        tick;
        rst = 0;
        s_arvalid = 1; s_araddr = 32'h3004; s_arid = 4; s_arlen = 0;
        #1 chk("t6 m_arvalid", m_arvalid, 1);
        chk("t6 s_arready", s_arready, 1);
        tick;
        s_arvalid = 0;
        m_rvalid = 1; m_rlast = 1; m_rid = 4; m_rdata = 32'hABCD; m_rresp = 0;
        #1 chk("t6 s_rdata", s_rdata, 32'hABCD);
        chk("t6 s_rresp", s_rresp, 2'b00);
        tick;
        m_rvalid = 0; m_rlast = 0;
        tick;

        // simultaneous denied AW and AR give a single pulse
        v0 = n_viol;
        s_awvalid = 1; s_awaddr = 32'h0000_0000; s_awid = 9;
        s_arvalid = 1; s_araddr = 32'h8000; s_arid = 1; s_arlen = 0;
        tick;
        s_awvalid = 0; s_arvalid = 0;
        chk("t7 pulse", fw_violation, 1);
        s_wvalid = 1; s_wlast = 1;
        tick;
        s_wvalid = 0; s_wlast = 0;
        chk("t7 pulse width", fw_violation, 0);
        repeat (2) tick;
        chk("t7 single pulse", n_viol - v0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_master_firewall.md
Name: axi_master_firewall

Overview:
- Parametrised per-master AXI access-control stage between one NOC master port and the interconnect; generalises the fixed three-slave address check into an N-region, mask-programmable firewall.
- Allowed transactions pass through unchanged.
- Denied transactions are absorbed locally and completed with DECERR, so a bad address never reaches the fabric and never hangs the master.
- Instantiated once per master (M0..M3); M2 uses ALLOW_MASK=7'b0010110 (S1, S2, S4).

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- ID_W, 4, AXI ID width.
- NUM_SLAVES, 7, number of decoded regions.
- ALLOW_MASK, 7'b0010110, bit k=1 permits slave k.
- MAX_OUT, 8, max outstanding allowed writes and, separately, max outstanding allowed reads.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- s_aw{id,addr,len,size,burst,lock,cache,prot,qos,region,valid}  in  ID_W/ADDR_W/4/3/2/1/4/3/4/4/1  upstream write address.
- s_awready  out  1  upstream write-address ready.
- s_w{data,strb,last,valid}  in  DATA_W/DATA_W/8/1/1  upstream write data.
- s_wready  out  1  upstream write-data ready.
- s_b{id,resp,valid}  out  ID_W/2/1  upstream write response.
- s_bready  in  1  upstream response ready.
- s_ar{id,addr,len,size,burst,lock,cache,prot,qos,region,valid}  in  as s_aw*  upstream read address.
- s_arready  out  1  upstream read-address ready.
- s_r{id,data,resp,last,valid}  out  ID_W/DATA_W/2/1/1  upstream read data.
- s_rready  in  1  upstream read ready.
- m_* (all channels)  mirrored directions  same widths  downstream to NOC.
- fw_violation  out  1  one-cycle pulse when a denied AW or AR is accepted.

Behaviour:
- Decode (combinational):
  - Region k is [REGION_BASE[k], REGION_BASE[k]+0xFFF], with REGION_BASE taken from the package.
  - An address is allowed iff it hits region k and ALLOW_MASK[k]=1.
  - An address hitting no region is denied.
  - Decode uses the start address only; bursts crossing a region boundary are not checked.
- Write FSM, states W_PASS, W_DRAIN, W_RESP:
  - W_PASS, allowed AW:
    - m_awvalid=s_awvalid and s_awready=m_awready, unless wr_out==MAX_OUT (then both are 0).
    - W passes through; B passes through.
    - wr_out increments on an m_aw handshake and decrements on an m_b handshake; both in the same cycle gives a net 0 change.
  - W_PASS, denied AW:
    - m_awvalid=0.
    - s_awready=1 only when wr_out==0, so all prior W beats and B responses have drained.
    - On the handshake: latch awid, pulse fw_violation, go to W_DRAIN.
  - W_DRAIN: s_wready=1 and m_wvalid=0; discard beats. An s_wlast handshake goes to W_RESP.
  - W_RESP: s_bvalid=1, s_bid=latched id, s_bresp=2'b11. An s_bready handshake goes to W_PASS.
  - s_awready=0 in W_DRAIN and W_RESP.
- Read FSM, states R_PASS, R_ERR:
  - Allowed AR and R pass through, tracked by rd_out with the same MAX_OUT stall rule.
  - Denied AR is accepted only when rd_out==0. On the handshake: latch arid and arlen, beat counter=0, pulse fw_violation, go to R_ERR.
  - R_ERR drives s_rvalid=1, s_rdata=0, s_rresp=2'b11, s_rid=latched id, and s_rlast when beat==arlen.
  - The beat counter increments on each s_r handshake; a handshake with rlast returns to R_PASS.
  - In R_ERR: s_arready=0 and m_rready=0.
- Write and read FSMs are independent.
- A simultaneous denied AW and denied AR in one cycle raises one fw_violation pulse.
- Reset (asynchronous, any state): FSMs go to PASS; counters clear; s_bvalid, s_rvalid, fw_violation, m_awvalid, m_arvalid, m_wvalid all 0. An in-flight error response is dropped.
- Latency: zero cycles for pass-through. The first DECERR B or R is driven the cycle after the terminating handshake.

Optional Feature:
- FW_VIOLATION_LOG_EN defined adds three outputs:
  - fw_viol_cnt [15:0]: saturating count of denied requests.
  - fw_first_addr [ADDR_W-1:0]: sticky address of the first denied request.
  - fw_first_is_wr [0:0]: sticky, set if that request was a write.
  - All three clear only on rst.
- Undefined: these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Package axi_fw_pkg holds: REGION_BASE array, REGION_SIZE=0x1000, RESP_OKAY=2'b00, RESP_DECERR=2'b11, FSM state enums, and the function fw_region_allowed(addr, mask).
- One sub-module, axi_fw_err_rd_gen, containing the R_ERR beat generator.

Test Plan:
- Allowed write: AW addr 0x2010, len 3, four W beats, slave B OKAY → all beats pass through, s_bresp=00, fw_violation stays 0.
- Denied write: AW addr 0x6000, id 5, len 1, two W beats → m_awvalid/m_wvalid never assert, B id 5 resp 11 one cycle after the second wlast, one fw_violation pulse.
- Denied read: AR addr 0x1000, id 3, len 3, with s_rready toggled 1,0,1,1,1 → exactly four R beats, rdata 0, resp 11, rlast on the fourth.
- Outstanding limit: nine allowed AWs with B withheld → the ninth stalls until one B returns.
- Denied AW while wr_out=2 → s_awready held 0 until both B responses complete, then accepted.
- rst pulse mid-R_ERR after two of four beats → s_rvalid=0 the same cycle; FSM back in R_PASS; the next allowed AR passes.
